// File: rtl/id_regfile_gen_pkg.sv
// Shared types and defaults for the id-stage register file.
// Holds the FSM state enum, parameter defaults and strobe width.
package id_regfile_gen_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NRD    = 2;
  localparam int DEF_STRB_W = DEF_DATA_W / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/id_regfile_gen_byte_merge.sv
// Byte-lane merge: old word, new word, strobes -> merged word.
// Ports: i_old, i_new (DATA_W), i_strb (DATA_W/8), o_merged (DATA_W).
module regfile_byte_merge
  import id_regfile_gen_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  localparam int STRB_W = strb_w(DATA_W)
) (
  input  logic [DATA_W-1:0] i_old,
  input  logic [DATA_W-1:0] i_new,
  input  logic [STRB_W-1:0] i_strb,
  output logic [DATA_W-1:0] o_merged
);

  always_comb begin
    o_merged = i_old;
    for (int i = 0; i < STRB_W; i++) begin
      if (i_strb[i]) begin
        o_merged[8*i +: 8] = i_new[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/id_regfile_gen.sv
// Register file with byte strobes, write-through bypass and FSM clear.
// Ports: clk, rst (async high), clr, raddr/rdata (NRD ports),
//        wen/waddr/wdata/wstrb write port, ready.
module id_regfile_gen
  import id_regfile_gen_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int ADDR_W = DEF_ADDR_W,
  parameter  int NRD    = DEF_NRD,
  localparam int STRB_W = strb_w(DATA_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  input  logic                  wen,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [STRB_W-1:0]     wstrb,
  output logic                  ready
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  state_e            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_ready;

  logic              w_wr_ok;
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_merged;

  // A clr in the same cycle wins over the write.
  assign w_wr_ok = r_ready && wen && !clr &&
                   (waddr != '0);
  assign w_old   = r_mem[waddr];
  assign ready   = r_ready;

  // One merge feeds both the array write and the bypass.
  regfile_byte_merge #(
    .DATA_W   (DATA_W)
  ) u_merge (
    .i_old    (w_old),
    .i_new    (wdata),
    .i_strb   (wstrb),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      unique case (r_state)
        ST_CLEAR: begin
          if (clr) begin
            r_cnt <= '0;
          end else if (r_cnt == '1) begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_READY: begin
          if (clr) begin
            r_state <= ST_CLEAR;
            r_ready <= 1'b0;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

  // Storage is never reset; the CLEAR walk zeroes it.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR && !clr) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_ok) begin
      r_mem[waddr] <= w_merged;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rd;

    assign w_ra = raddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      if (!r_ready || w_ra == '0) begin
        w_rd = '0;
      end else if (w_wr_ok && w_ra == waddr) begin
        w_rd = w_merged;
      end else begin
        w_rd = r_mem[w_ra];
      end
    end

    assign rdata[k*DATA_W +: DATA_W] = w_rd;
  end

endmodule

// File: tb/tb_id_regfile_gen.sv
// Self-checking bench for id_regfile_gen.
// Table vectors, scoreboard queue and multi-cycle sequences.
module tb_id_regfile_gen;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              clr;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*DW-1:0] rdata;
  logic              wen;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic [3:0]        wstrb;
  logic              ready;

  id_regfile_gen dut (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .raddr (raddr),
    .rdata (rdata),
    .wen   (wen),
    .waddr (waddr),
    .wdata (wdata),
    .wstrb (wstrb),
    .ready (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sbq[$];
  logic [31:0] mdl[32];
  vec_t        tbl[10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w,
                       input logic [4:0] wa,
                       input logic [31:0] wd,
                       input logic [3:0] ws,
                       input logic [4:0] ra0,
                       input logic [4:0] ra1);
    wen   = w;
    waddr = wa;
    wdata = wd;
    wstrb = ws;
    raddr = {ra1, ra0};
  endtask

  task automatic push2(input logic [31:0] e0,
                       input logic [31:0] e1);
    sbq.push_back(e0);
    sbq.push_back(e1);
  endtask

  task automatic pop2(input string nm);
    #1;
    if (sbq.size() < 2) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", nm);
    end else begin
      chk({nm, ".p0"}, rdata[31:0], sbq.pop_front());
      chk({nm, ".p1"}, rdata[63:32], sbq.pop_front());
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 64) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] o,
                                      input logic [31:0] d,
                                      input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0] = '{1'b1, 5'd5, 32'hAABBCCDD, 4'hF, 5'd5, 5'd0,
               32'hAABBCCDD, 32'h0};
    tbl[1] = '{1'b1, 5'd5, 32'h11223344, 4'h5, 5'd5, 5'd5,
               32'hAA22CC44, 32'hAA22CC44};
    tbl[2] = '{1'b0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd7,
               32'hAA22CC44, 32'h0};
    tbl[3] = '{1'b1, 5'd7, 32'h12345678, 4'hF, 5'd7, 5'd5,
               32'h12345678, 32'hAA22CC44};
    tbl[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 5'd7,
               32'h0, 32'h12345678};
    tbl[5] = '{1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0,
               32'h0, 32'h0};
    tbl[6] = '{1'b1, 5'd7, 32'hDEADBEEF, 4'h0, 5'd7, 5'd5,
               32'h12345678, 32'hAA22CC44};
    tbl[7] = '{1'b1, 5'd9, 32'h000000EE, 4'h1, 5'd9, 5'd9,
               32'h000000EE, 32'h000000EE};
    tbl[8] = '{1'b1, 5'd9, 32'h0000FF00, 4'h2, 5'd9, 5'd8,
               32'h0000FFEE, 32'h0};
    tbl[9] = '{1'b0, 5'd0, 32'h0, 4'h0, 5'd9, 5'd7,
               32'h0000FFEE, 32'h12345678};

    rst = 1'b1;
    clr = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd1, 5'd3);
    repeat (2) tick();
    #1;
    chk("rst.ready", {31'b0, ready}, 32'h0);
    chk("rst.rd0", rdata[31:0], 32'h0);
    chk("rst.rd1", rdata[63:32], 32'h0);

    rst = 1'b0;
    wait_ready(n);
    chk("rst.latency", n, 32);
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(31 - a), 5'(a)};
      push2(32'h0, 32'h0);
      pop2($sformatf("zero%0d", a));
    end

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].ws,
            tbl[i].ra0, tbl[i].ra1);
      push2(tbl[i].e0, tbl[i].e1);
      pop2($sformatf("vec%0d", i));
      tick();
    end

    drive(1'b1, 5'd3, 32'h55, 4'hF, 5'd3, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd0);
    push2(32'h55, 32'h0);
    pop2("clr.pre");
    clr = 1'b1;
    drive(1'b1, 5'd3, 32'h77, 4'hF, 5'd3, 5'd0);
    tick();
    clr = 1'b0;
    drive(1'b1, 5'd3, 32'h99, 4'hF, 5'd3, 5'd0);
    push2(32'h0, 32'h0);
    pop2("clr.during");
    chk("clr.ready", {31'b0, ready}, 32'h0);
    wait_ready(n);
    wen = 1'b0;
    chk("clr.latency", n, 32);
    push2(32'h0, 32'h0);
    pop2("clr.post");

    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (9) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wait_ready(n);
    chk("clr.restart", n, 32);

    drive(1'b1, 5'd7, 32'hCAFEF00D, 4'hF, 5'd7, 5'd7);
    push2(32'hCAFEF00D, 32'hCAFEF00D);
    pop2("mw.bypass");
    rst = 1'b1;
    push2(32'h0, 32'h0);
    pop2("mw.rst");
    chk("mw.ready", {31'b0, ready}, 32'h0);
    tick();
    rst = 1'b0;
    wen = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    #1;
    chk("mc.ready", {31'b0, ready}, 32'h0);
    tick();
    rst = 1'b0;
    wait_ready(n);
    chk("mc.latency", n, 32);

    for (int a = 0; a < 32; a++) mdl[a] = 32'h0;
    for (int i = 0; i < 60; i++) begin
      logic [4:0]  wa, r0, r1;
      logic [31:0] wd, e0, e1;
      logic [3:0]  ws;
      logic        w;
      w  = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 7));
      wd = $urandom;
      ws = 4'($urandom_range(0, 15));
      r0 = 5'($urandom_range(0, 7));
      r1 = 5'($urandom_range(0, 7));
      e0 = (r0 == 0) ? 32'h0 :
           (w && wa != 0 && r0 == wa) ? mrg(mdl[wa], wd, ws) :
           mdl[r0];
      e1 = (r1 == 0) ? 32'h0 :
           (w && wa != 0 && r1 == wa) ? mrg(mdl[wa], wd, ws) :
           mdl[r1];
      drive(w, wa, wd, ws, r0, r1);
      push2(e0, e1);
      pop2($sformatf("rnd%0d", i));
      tick();
      if (w && wa != 0) mdl[wa] = mrg(mdl[wa], wd, ws);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_regfile_gen.md
ID_REGFILE_GEN -- requirements
Module: id_regfile_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits; legal values are multiples of 8.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter NRD, default 2, number of read ports; legal range 1..4.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-006 SHALL have port clr, input, 1, synchronous soft-clear request.
REQ-007 SHALL have port raddr, input, NRD*ADDR_W, read addresses; port k uses slice k.
REQ-008 SHALL have port rdata, output, NRD*DATA_W, read data; port k uses slice k.
REQ-009 SHALL have port wen, input, 1, write enable.
REQ-010 SHALL have port waddr, input, ADDR_W, write address.
REQ-011 SHALL have port wdata, input, DATA_W, write data.
REQ-012 SHALL have port wstrb, input, DATA_W/8, byte write strobes; bit i covers bits 8i+7..8i.
REQ-013 SHALL have port ready, output, 1, high when the file accepts writes and returns stored data.

Function
REQ-014 SHALL implement a two-state FSM: CLEAR and READY.
REQ-015 CLEAR SHALL write zero to one register per cycle, indexed by a clear counter running 0..DEPTH-1.
REQ-016 CLEAR SHALL transition to READY on the cycle that clears register DEPTH-1; ready rises in the following cycle.
REQ-017 The CLEAR sequence SHALL therefore take exactly DEPTH cycles.
REQ-018 In READY, clr=1 SHALL return the FSM to CLEAR with the counter reset to 0; a write in that same cycle SHALL be dropped.
REQ-019 clr asserted during CLEAR SHALL restart the counter at 0.
REQ-020 In READY, when wen=1 and waddr!=0, each byte i with wstrb[i]=1 SHALL take wdata byte i; bytes with wstrb[i]=0 SHALL be unchanged.
REQ-021 In READY, a write with wstrb all zero SHALL leave the register unchanged.
REQ-022 Writes to address 0 SHALL be ignored; register 0 SHALL always read 0.
REQ-023 Writes SHALL be ignored while ready=0.
REQ-024 Each rdata port SHALL be combinational from raddr, with zero added latency.
REQ-025 Write-through bypass: in READY, when wen=1, waddr!=0, and raddr[k]==waddr, rdata[k] SHALL equal the byte-merged value that will be stored at the next edge.
REQ-026 All read ports SHALL bypass independently; equal addresses on several ports SHALL return identical data.
REQ-027 While ready=0, every rdata port SHALL return 0.

Reset
REQ-028 rst=1 SHALL immediately force the FSM to CLEAR, the counter to 0, and ready to 0.
REQ-029 rdata SHALL read 0 during reset, including an assertion mid-write or mid-clear.
REQ-030 Array contents SHALL be undefined until the post-reset CLEAR completes.
REQ-031 After rst deasserts, ready SHALL rise DEPTH cycles later.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the DATA_W/ADDR_W/NRD defaults, and the strobe-width constant DATA_W/8.
REQ-033 Byte merging SHALL live in one sub-module, regfile_byte_merge (old word, new word, strobes -> merged word).
REQ-034 That sub-module SHALL be shared by the write path and the bypass path.
REQ-035 The storage array SHALL not be reset directly; clearing happens only via the FSM.

Verification
REQ-036 Reset release: rst pulse, defaults -> ready=0 for 32 cycles, ready=1 at cycle 32, all reads 0.
REQ-037 Byte strobe: write r5=0xAABBCCDD with strobe 1111, then write 0x11223344 with strobe 0101 -> r5 reads 0xAA22CC44.
REQ-038 Bypass: same-cycle wen=1, waddr=7, wdata=0x12345678, strobe 1111, raddr0=7 -> rdata0=0x12345678 in that cycle.
REQ-039 Register zero: write 0xFFFFFFFF to address 0 -> read of address 0 returns 0, both combinationally and afterwards.
REQ-040 Soft clear: r3=0x55 and clr=1 -> writes dropped for 32 cycles, then r3 reads 0; clr again at cycle 10 restarts the count.
REQ-041 Mid-clear reset: rst asserted at clear cycle 20 -> ready stays 0, counter returns to 0, full 32-cycle CLEAR runs after release.
